// File: rtl/cmp_search.sv
// Binary search of a hidden value through an external magnitude comparator.
// One probe is a CALC cycle followed by a PROBE wait for the response.
module cmp_search #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic [WIDTH-1:0]             guess,
    output logic                         guess_valid,
    input  logic                         resp_valid,
    input  logic                         gt,
    input  logic                         eq,
    input  logic                         lt,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             found,
    output logic                         err,
    output logic [$clog2(WIDTH+2)-1:0]   steps
);

    localparam int SW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        PROBE,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] found_q, found_d;
    logic             err_q, err_d;
    logic [SW-1:0]    steps_q, steps_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '1;
            guess_q <= '0;
            found_q <= '0;
            err_q   <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            guess_q <= guess_d;
            found_q <= found_d;
            err_q   <= err_d;
            steps_q <= steps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        guess_d = guess_q;
        found_d = found_q;
        err_d   = err_q;
        steps_d = steps_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = '1;
                    steps_d = '0;
                    err_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // hi >= lo always holds, so the difference cannot wrap
                guess_d = lo_q + ((hi_q - lo_q) >> 1);
                state_d = PROBE;
            end
            PROBE: begin
                if (resp_valid) begin
                    steps_d = (&steps_q) ? steps_q : steps_q + SW'(1);
                    state_d = FIN;
                    err_d   = 1'b1;
                    case ({gt, eq, lt})
                        3'b010: begin
                            found_d = guess_q;
                            err_d   = 1'b0;
                        end
                        3'b100: begin
                            if (!(guess_q == '1 || guess_q == hi_q)) begin
                                lo_d    = guess_q + WIDTH'(1);
                                err_d   = 1'b0;
                                state_d = CALC;
                            end
                        end
                        3'b001: begin
                            if (!(guess_q == '0 || guess_q == lo_q)) begin
                                hi_d    = guess_q - WIDTH'(1);
                                err_d   = 1'b0;
                                state_d = CALC;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign guess       = guess_q;
    assign guess_valid = (state_q == PROBE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign found       = found_q;
    assign err         = err_q;
    assign steps       = steps_q;

endmodule

// File: tb/tb_cmp_search.sv
// Self-checking bench for cmp_search: randomized responder timing and noise
// checked against an integer binary-search reference.
module tb_cmp_search;

    localparam int W  = 8;
    localparam int SW = $clog2(W + 2);
    localparam int MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          resp_valid = 1'b0;
    logic          gt = 1'b0;
    logic          eq = 1'b0;
    logic          lt = 1'b0;
    logic [W-1:0]  guess;
    logic [W-1:0]  found;
    logic          guess_valid;
    logic          busy;
    logic          done;
    logic          err;
    logic [SW-1:0] steps;

    int checks = 0;
    int failures = 0;

    int exp_g[$];
    int exp_steps;
    int exp_err;

    always #5 clk = ~clk;

    cmp_search #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .guess(guess),
        .guess_valid(guess_valid),
        .resp_valid(resp_valid),
        .gt(gt),
        .eq(eq),
        .lt(lt),
        .busy(busy),
        .done(done),
        .found(found),
        .err(err),
        .steps(steps)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_guess"}, int'(guess), 0);
        check({tag, "_gv"}, int'(guess_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_found"}, int'(found), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_steps"}, int'(steps), 0);
    endtask

    // mode 0: honest comparator, 1: always gt, 2: 110 on first probe
    task automatic model(input int secret, input int mode);
        int lo;
        int hi;
        int g;
        bit fin;
        lo = 0;
        hi = MAXV;
        fin = 0;
        exp_g.delete();
        exp_err = 0;
        while (!fin) begin
            g = (lo + hi) / 2;
            exp_g.push_back(g);
            if (mode == 2) begin
                exp_err = 1;
                fin = 1;
            end else if (mode == 0 && g == secret) begin
                fin = 1;
            end else if (mode == 1 || secret > g) begin
                if (g == hi) begin
                    exp_err = 1;
                    fin = 1;
                end else begin
                    lo = g + 1;
                end
            end else begin
                if (g == lo) begin
                    exp_err = 1;
                    fin = 1;
                end else begin
                    hi = g - 1;
                end
            end
        end
        exp_steps = exp_g.size();
    endtask

    task automatic respond(input int secret, input int mode, input int g);
        case (mode)
            1: {gt, eq, lt} = 3'b100;
            2: {gt, eq, lt} = 3'b110;
            default: begin
                gt = (secret > g);
                eq = (secret == g);
                lt = (secret < g);
            end
        endcase
    endtask

    task automatic run_search(input int secret, input int delay,
                              input int mode, input int abort_probe);
        int probe;
        int wait_cnt;
        int cyc;
        int held;
        logic prev_gv;
        model(secret, mode);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("gv_in_calc", int'(guess_valid), 0);
        probe = 0;
        wait_cnt = 0;
        cyc = 0;
        held = 0;
        prev_gv = 1'b0;
        while (!done && cyc < 500) begin
            if (guess_valid && !prev_gv) begin
                probe++;
                if (probe == abort_probe) begin
                    rst_n = 1'b0;
                    #1;
                    check_reset_vals("mid_reset");
                    start = 1'b0;
                    resp_valid = 1'b0;
                    #2;
                    rst_n = 1'b1;
                    repeat (2) @(negedge clk);
                    check("idle_after_reset_busy", int'(busy), 0);
                    check("idle_after_reset_steps", int'(steps), 0);
                    return;
                end
                if (probe <= exp_g.size())
                    check($sformatf("guess_p%0d", probe), int'(guess), exp_g[probe-1]);
                else
                    check("extra_probe", probe, exp_g.size());
                held = int'(guess);
                wait_cnt = 0;
            end
            if (guess_valid) begin
                if (delay > 0)
                    check("guess_stable", int'(guess), held);
                if (wait_cnt >= delay) begin
                    resp_valid = 1'b1;
                    respond(secret, mode, int'(guess));
                end else begin
                    resp_valid = 1'b0;
                    {gt, eq, lt} = 3'($urandom);
                end
                wait_cnt++;
            end else begin
                resp_valid = 1'($urandom);
                {gt, eq, lt} = 3'($urandom);
            end
            start = 1'($urandom);
            prev_gv = guess_valid;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        resp_valid = 1'b0;
        if (!done) begin
            check("timeout_waiting_done", 0, 1);
            return;
        end
        check("probe_count", probe, exp_steps);
        check("fin_steps", int'(steps), exp_steps);
        check("fin_err", int'(err), exp_err);
        check("fin_busy", int'(busy), 1);
        if (exp_err == 0)
            check("fin_found", int'(found), secret);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("busy_fall", int'(busy), 0);
        repeat (2) @(negedge clk);
        check("err_hold", int'(err), exp_err);
        check("steps_hold", int'(steps), exp_steps);
        if (exp_err == 0)
            check("found_hold", int'(found), secret);
    endtask

    initial begin
        #1;
        check_reset_vals("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no_start_busy", int'(busy), 0);

        run_search(127, 0, 0, 0);
        run_search(0, 0, 0, 0);
        run_search(255, 0, 0, 0);
        run_search(200, 0, 0, 0);
        run_search(200, 5, 0, 0);
        run_search(0, 0, 1, 0);
        run_search(0, 0, 2, 0);
        run_search(100, 0, 0, 3);
        run_search(42, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            run_search(int'($urandom_range(0, MAXV)),
                       int'($urandom_range(0, 3)), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmp_search.md
CMP_SEARCH -- requirements
Module: cmp_search

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the searched value and of the guess bus.
REQ-002 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n: input, 1 bit, reset; asynchronous, active-low.
REQ-004 Port start: input, 1 bit, begins a search when sampled high in IDLE.
REQ-005 Port guess: output, WIDTH bits, value driven to the external comparator B input (secret on A).
REQ-006 Port guess_valid: output, 1 bit, guess is stable and awaiting a response.
REQ-007 Port resp_valid: input, 1 bit, the comparator response is valid this cycle.
REQ-008 Port gt, eq, lt: inputs, 1 bit each, comparator result; gt means secret > guess, lt means secret < guess, eq means secret == guess.
REQ-009 Port busy: output, 1 bit, high in every state except IDLE.
REQ-010 Port done: output, 1 bit, one-cycle pulse at search completion (success or error).
REQ-011 Port found: output, WIDTH bits, located secret; valid when done pulses with err low.
REQ-012 Port err: output, 1 bit, search ended without a match; held until the next accepted start.
REQ-013 Port steps: output, $clog2(WIDTH+2) bits, number of responses accepted in the current or last search.

Function
REQ-014 The module SHALL implement the states IDLE, CALC, PROBE and FIN.
REQ-015 IDLE: start=1 SHALL load lo=0, hi=2^WIDTH-1, steps=0, clear err, and go to CALC; start=0 stays in IDLE.
REQ-016 CALC (one cycle, guess_valid=0): guess SHALL be set to lo + ((hi-lo)>>1), computed without overflow, then go to PROBE.
REQ-017 PROBE: guess_valid=1 and guess held constant until a cycle with resp_valid=1; the response SHALL be accepted in that cycle.
REQ-018 Accept: steps increments by 1 (saturating at all-ones).
REQ-019 Accept with eq only: found=guess, err=0, go to FIN.
REQ-020 Accept with gt only: if guess==2^WIDTH-1 or guess==hi, set err=1 and go to FIN; else set lo=guess+1 and go to CALC.
REQ-021 Accept with lt only: if guess==0 or guess==lo, set err=1 and go to FIN; else set hi=guess-1 and go to CALC.
REQ-022 Accept with a non-one-hot response ({gt,eq,lt} = 000, 011, 101, 110 or 111): set err=1 and go to FIN.
REQ-023 FIN: done=1 for exactly one cycle, then go to IDLE; found, err and steps SHALL hold until the next accepted start.
REQ-024 start SHALL be ignored in every state except IDLE; resp_valid SHALL be ignored in every state except PROBE.
REQ-025 A consistent comparator SHALL yield a match within WIDTH+1 accepted responses (9 for WIDTH=8).
REQ-026 Minimum time per probe: 2 cycles (CALC + PROBE with resp_valid already high).

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, guess=0, guess_valid=0, busy=0, done=0, found=0, err=0, steps=0, lo=0 and hi=all-ones, including when reset occurs mid-search.
REQ-028 After rst_n rises, the first search SHALL start only on a start sampled high at a clock edge.

Verification (WIDTH=8, behavioural comparator model, resp_valid high in PROBE unless stated)
REQ-029 Secret=127 -> first guess 127, eq -> found=127, err=0, steps=1, done one cycle.
REQ-030 Secret=0 -> guesses 127,63,31,15,7,3,1,0 -> found=0, steps=8; secret=255 -> guesses 127,191,223,239,247,251,253,254,255 -> found=255, steps=9.
REQ-031 Responder delays resp_valid by 5 cycles on every probe, secret=200 -> guess stable while guess_valid=1, found=200, steps unchanged from the zero-delay run.
REQ-032 Faulty responder returns gt for every guess -> err=1 on the guess==255 probe, done pulses, busy falls the next cycle.
REQ-033 {gt,eq,lt}=110 on the first probe -> err=1, steps=1; start pulsed while busy -> no effect.
REQ-034 rst_n asserted during the third probe -> all outputs reach reset values without waiting for a clock edge; a new start then finds secret=42 normally.
